// File: rtl/comb_launch_capture.sv
// Launch/capture harness around an external combinational block.
// Operands launch from registers, settle for SETTLE_CYCLES, then the result is captured.

module comb_launch_capture #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    output logic [WIDTH-1:0] comb_x,
    output logic [WIDTH-1:0] comb_y,
    input  logic [WIDTH-1:0] comb_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("comb_launch_capture: SETTLE_CYCLES must lie in 1..255");
    end

    localparam logic [7:0] SettleInit = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e           state_q;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;

    // Operand registers only move on an accept edge, so the path under test
    // never toggles outside a launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        x_q     <= req_x;
                        y_q     <= req_y;
                        cnt_q   <= SettleInit;
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == 8'd1) begin
                        data_q  <= comb_out;
                        valid_q <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign comb_x     = x_q;
    assign comb_y     = y_q;
    assign rsp_valid  = valid_q;
    assign rsp_data   = data_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_comb_launch_capture.sv
// Scoreboard bench: three instances (settle 1, settle 4 with slow block model, settle 2 with
// 4-bit counter); expected results are queued at issue and checked by a response monitor.

module tb_comb_launch_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid [3];
    logic       req_ready [3];
    logic [7:0] req_x     [3];
    logic [7:0] req_y     [3];
    logic [7:0] comb_x    [3];
    logic [7:0] comb_y    [3];
    logic [7:0] comb_out  [3];
    logic       rsp_valid [3];
    logic       rsp_ready [3];
    logic [7:0] rsp_data  [3];
    logic       busy      [3];
    logic [15:0] xfer0;
    logic [15:0] xfer1;
    logic [3:0]  xfer2;

    typedef struct {
        int         lane;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   acc_cyc;
    int   age1   = 15;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comb_launch_capture #(.WIDTH(8), .SETTLE_CYCLES(1), .CNT_W(16)) u_s1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_x(req_x[0]), .req_y(req_y[0]), .comb_x(comb_x[0]), .comb_y(comb_y[0]),
        .comb_out(comb_out[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .busy(busy[0]), .xfer_count(xfer0)
    );

    comb_launch_capture #(.WIDTH(8), .SETTLE_CYCLES(4), .CNT_W(16)) u_s4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_x(req_x[1]), .req_y(req_y[1]), .comb_x(comb_x[1]), .comb_y(comb_y[1]),
        .comb_out(comb_out[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .busy(busy[1]), .xfer_count(xfer1)
    );

    comb_launch_capture #(.WIDTH(8), .SETTLE_CYCLES(2), .CNT_W(4)) u_s2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_x(req_x[2]), .req_y(req_y[2]), .comb_x(comb_x[2]), .comb_y(comb_y[2]),
        .comb_out(comb_out[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_data(rsp_data[2]), .busy(busy[2]), .xfer_count(xfer2)
    );

    // Slow block on lane 1: valid only from 3 edges after launch; 8'h00 stands in for X.
    always @(posedge clk) begin
        if (req_valid[1] && req_ready[1]) age1 <= 0;
        else if (age1 != 15)             age1 <= age1 + 1;
    end

    assign comb_out[0] = comb_x[0] ^ comb_y[0];
    assign comb_out[1] = (age1 >= 3) ? (comb_x[1] ^ comb_y[1]) : 8'h00;
    assign comb_out[2] = comb_x[2] ^ comb_y[2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Handshake happens on the next rising edge when both are high here.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < 3; l++) begin
                if (rsp_valid[l] && rsp_ready[l]) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_rsp: lane %0d data %0h, required none", l,
                                 rsp_data[l]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("rsp_lane", l, e.lane);
                        check("rsp_data", rsp_data[l], e.data);
                    end
                end
            end
        end
    end

    task automatic issue(input int l, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] exp, input bit push);
        int t;
        t = 0;
        req_x[l] = x;
        req_y[l] = y;
        req_valid[l] = 1'b1;
        while (!req_ready[l] && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready[l]) begin
            check("accept_timeout", req_ready[l], 1);
        end else begin
            if (push) exp_q.push_back('{l, exp});
            @(posedge clk); #1;
            acc_cyc = cyc;
            check("launch_x", comb_x[l], x);
            check("launch_y", comb_y[l], y);
        end
    endtask

    task automatic wait_rsp(input int l, input int lat);
        int n;
        n = 0;
        while (!rsp_valid[l] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_latency", n, lat);
    endtask

    task automatic wait_idle(input int l);
        int n;
        n = 0;
        while (busy[l] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", busy[l], 0);
    endtask

    logic [7:0] tp_x [5] = '{8'h12, 8'hF0, 8'h80, 8'h3C, 8'hDE};
    logic [7:0] tp_y [5] = '{8'h34, 8'h0F, 8'h01, 8'h5A, 8'hAD};
    logic [7:0] tp_e [5] = '{8'h26, 8'hFF, 8'h81, 8'h66, 8'h73};

    initial begin
        int prev;
        rst_n = 1'b0;
        for (int l = 0; l < 3; l++) begin
            req_valid[l] = 1'b0;
            req_x[l]     = 8'h00;
            req_y[l]     = 8'h00;
            rsp_ready[l] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int l = 0; l < 3; l++) begin
            check("rst_rsp_valid", rsp_valid[l], 0);
            check("rst_busy", busy[l], 0);
            check("rst_comb_x", comb_x[l], 0);
            check("rst_comb_y", comb_y[l], 0);
            check("rst_rsp_data", rsp_data[l], 0);
        end
        check("rst_xfer0", xfer0, 0);
        check("rst_xfer1", xfer1, 0);
        check("rst_xfer2", xfer2, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            for (int l = 0; l < 3; l++) check("idle_req_ready", req_ready[l], 1);
        end

        // Single transaction, settle 1.
        rsp_ready[0] = 1'b1;
        issue(0, 8'hA5, 8'h0F, 8'hAA, 1'b1);
        req_valid[0] = 1'b0;
        wait_rsp(0, 1);
        wait_idle(0);
        check("single_xfer", xfer0, 1);

        // Multicycle settle: capture must wait for edge 4.
        rsp_ready[1] = 1'b1;
        issue(1, 8'hFF, 8'h01, 8'hFE, 1'b1);
        req_valid[1] = 1'b0;
        wait_rsp(1, 4);
        wait_idle(1);
        check("settle4_xfer", xfer1, 1);

        // Backpressure with req_valid held and operands changing.
        rsp_ready[0] = 1'b0;
        issue(0, 8'h3C, 8'hC3, 8'hFF, 1'b1);
        req_x[0] = 8'h11;
        req_y[0] = 8'h22;
        wait_rsp(0, 1);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", rsp_valid[0], 1);
            check("bp_rsp_data", rsp_data[0], 8'hFF);
            check("bp_req_ready", req_ready[0], 0);
            check("bp_comb_x", comb_x[0], 8'h3C);
            check("bp_xfer", xfer0, 1);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_xfer_inc", xfer0, 2);
        check("bp_comb_x_hold", comb_x[0], 8'h3C);
        repeat (2) @(posedge clk);
        #1;
        check("bp_xfer_once", xfer0, 2);

        // Back-to-back at settle 2: accepts every 4 cycles.
        rsp_ready[2] = 1'b1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            issue(2, tp_x[i], tp_y[i], tp_e[i], 1'b1);
            if (i > 0) check("accept_spacing", acc_cyc - prev, 4);
            prev = acc_cyc;
        end
        req_valid[2] = 1'b0;
        wait_idle(2);
        check("b2b_xfer", xfer2, 5);

        // Twelve more to reach 17: the 4-bit count wraps to 1.
        for (int i = 0; i < 12; i++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = 8'(i * 17 + 3);
            y = 8'(8'hC5 - i);
            issue(2, x, y, x ^ y, 1'b1);
        end
        req_valid[2] = 1'b0;
        wait_idle(2);
        check("wrap_xfer", xfer2, 1);

        // Reset while lane 1 is settling: aborts without a response.
        issue(1, 8'h12, 8'h34, 8'h00, 1'b0);
        req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_abort_busy", busy[1], 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy[1], 0);
        check("abort_req_ready", req_ready[1], 1);
        check("abort_comb_x", comb_x[1], 0);
        check("abort_comb_y", comb_y[1], 0);
        check("abort_rsp_valid", rsp_valid[1], 0);
        check("abort_rsp_data", rsp_data[1], 0);
        check("abort_xfer1", xfer1, 0);
        check("abort_xfer0", xfer0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            check("abort_no_rsp", rsp_valid[1], 0);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/comb_launch_capture.md
Name: comb_launch_capture

Overview:
- Sequential initiator that sits on the far side of the 8-bit bitwise combinational block.
- Accepts an operand pair over a valid/ready request channel and launches it from registers onto the block's x/y inputs.
- Waits a fixed number of settle cycles, treating the block as a multicycle path, then captures the block's output in a register.
- Returns the captured result over a valid/ready response channel.
- Provides the registered launch and capture boundary used for timing the combinational path.

Parameters:
- WIDTH, 8, operand and result width; matches the combinational block.
- SETTLE_CYCLES, 1, cycles from launch edge to capture edge; legal range 1..255.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request operands valid.
- req_ready  output  1  block can accept a request.
- req_x  input  WIDTH  operand x.
- req_y  input  WIDTH  operand y.
- comb_x  output  WIDTH  registered operand driven to the combinational block x input.
- comb_y  output  WIDTH  registered operand driven to the combinational block y input.
- comb_out  input  WIDTH  combinational block output.
- rsp_valid  output  1  captured result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  WIDTH  captured result.
- busy  output  1  high in any state other than IDLE.
- xfer_count  output  CNT_W  number of completed response handshakes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (asynchronous on rst_n low):
  - State = IDLE.
  - comb_x, comb_y, rsp_data, xfer_count = 0.
  - rsp_valid = 0, busy = 0, settle counter = 0.
  - req_ready = 1 once rst_n is high.
- Reset asserted mid-operation aborts the transaction immediately. No response is produced and xfer_count is not incremented.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready = 1.
  - On edge E0 with req_valid = 1: comb_x <= req_x, comb_y <= req_y, counter <= SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - req_ready = 0.
  - Counter decrements each edge.
  - On the edge where counter == 1 (edge E0 + SETTLE_CYCLES): rsp_data <= comb_out, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data is stable until the handshake.
  - On an edge with rsp_ready = 1: go to IDLE and increment xfer_count.
  - xfer_count wraps from all-ones to 0 with no saturation.
- Latency: rsp_valid first observed high in the cycle following edge E0 + SETTLE_CYCLES.
- Throughput: minimum request-to-request period of SETTLE_CYCLES + 2 cycles when rsp_ready is held at 1.
- Operand stability:
  - comb_x and comb_y change only on an IDLE accept edge.
  - They hold their values through SETTLE, RESP and the following IDLE period, so the path under test sees no toggling outside a launch.
- req_valid and req_ready:
  - req_ready depends only on state, with no combinational path from req_valid.
  - req_x and req_y are ignored outside the accept edge.
  - req_valid may drop without acceptance; nothing is latched in that case.
- rsp_valid: registered, and never deasserts without a handshake. rsp_ready is ignored outside RESP.
- Simultaneous events: no request is accepted in the same cycle as a response handshake. The next accept occurs one edge after returning to IDLE, at the earliest.
- comb_out: sampled only on the capture edge. Glitches during SETTLE do not affect rsp_data.
- busy: equals state != IDLE.
- Out-of-range parameter: SETTLE_CYCLES outside 1..255 is a synthesis-time error, implemented as an elaboration assertion.

Test Plan:
- Reset and idle:
  - Stimulus: reset asserted, then released with no traffic.
  - Required: all outputs 0 except req_ready = 1, and req_ready stays 1.
- Single transaction:
  - Setup: SETTLE_CYCLES = 1; bench models the combinational block as comb_out = comb_x ^ comb_y.
  - Stimulus: req_x = 8'hA5, req_y = 8'h0F, rsp_ready = 1.
  - Required: comb_x = A5 and comb_y = 0F after E0; rsp_valid high in the cycle after E1 with rsp_data = 8'hAA; xfer_count = 1.
- Multicycle settle:
  - Setup: SETTLE_CYCLES = 4; bench model delays comb_out by 3 cycles and drives X before that.
  - Stimulus: x = 8'hFF, y = 8'h01.
  - Required: rsp_data = 8'hFE; capture occurs at E4, not earlier.
- Response backpressure:
  - Stimulus: rsp_ready = 0 for 10 cycles while req_valid is held at 1.
  - Required: rsp_valid and rsp_data held for all 10 cycles; req_ready = 0 throughout; comb_x unchanged; exactly one increment of xfer_count after rsp_ready rises.
- Back-to-back throughput:
  - Setup: SETTLE_CYCLES = 2.
  - Stimulus: 5 requests with req_valid and rsp_ready held at 1.
  - Required: accepts spaced exactly 4 cycles apart; results in order; xfer_count = 5.
- Reset mid-operation and counter wrap:
  - Stimulus: assert rst_n low while in SETTLE.
  - Required: immediate return to reset values; no rsp_valid pulse.
  - Separately: with CNT_W = 4, complete 17 transactions; required xfer_count = 1.
